// File: rtl/shape_plot_if.sv
// Command handshake between the game datapath and the shape plot engine.
interface shape_plot_if #(
    parameter int unsigned X_W     = 8,
    parameter int unsigned Y_W     = 7,
    parameter int unsigned COLOR_W = 3
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_mode;
    logic [X_W-1:0]     cmd_x;
    logic [Y_W-1:0]     cmd_y;
    logic [X_W-1:0]     cmd_w;
    logic [Y_W-1:0]     cmd_h;
    logic [COLOR_W-1:0] cmd_color;

    modport master (output cmd_valid, cmd_mode, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
                    input  cmd_ready);
    modport slave  (input  cmd_valid, cmd_mode, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
                    output cmd_ready);
endinterface

// File: rtl/shape_plot_engine.sv
// Queued pixel-stream generator: buffers draw commands in a small FIFO and
// emits one clipped (x, y, colour, plot) slot per clock for the VGA adapter.
module shape_plot_engine #(
    parameter int unsigned X_W        = 8,
    parameter int unsigned Y_W        = 7,
    parameter int unsigned COLOR_W    = 3,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SCREEN_W   = 160,
    parameter int unsigned SCREEN_H   = 120
) (
    input  logic               clk,
    input  logic               resetn,
    shape_plot_if.slave        cmd,
    output logic [X_W-1:0]     x_out,
    output logic [Y_W-1:0]     y_out,
    output logic [COLOR_W-1:0] color_out,
    output logic               plot,
    output logic               busy,
    output logic               done
);
    localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW    = ((X_W > Y_W) ? X_W : Y_W) + 2;
    localparam int unsigned ENT_W = 2 + 2 * X_W + 2 * Y_W + COLOR_W;
    localparam logic [1:0] M_DR    = 2'b01;
    localparam logic [1:0] M_DL    = 2'b10;
    localparam logic [1:0] M_CLEAR = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} state_t;
    state_t state;

    logic [ENT_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        fifo_cnt, cnt_nxt;
    logic               push_c, pop_c;

    logic [1:0]         hd_mode;
    logic [X_W-1:0]     hd_x, hd_w;
    logic [Y_W-1:0]     hd_y, hd_h;
    logic [COLOR_W-1:0] hd_color;

    logic [1:0]         mode_q;
    logic [X_W-1:0]     ox_q, w_q, c_q;
    logic [Y_W-1:0]     oy_q, h_q, r_q;
    logic [COLOR_W-1:0] col_q;
    logic               last_q;

    logic               diag_c, zero_c, last_c, clip_c, row_end_c;
    logic [CW-1:0]      xs_c, ys_c;
    logic [X_W-1:0]     c_nxt;
    logic [Y_W-1:0]     r_nxt;

    assign push_c  = cmd.cmd_valid && cmd.cmd_ready;
    assign pop_c   = (state == S_IDLE) && (fifo_cnt != '0);
    assign cnt_nxt = fifo_cnt + (AW+1)'(push_c) - (AW+1)'(pop_c);
    assign {hd_mode, hd_x, hd_y, hd_w, hd_h, hd_color} = mem[rd_ptr];

    // Current slot coordinates; diagonals reuse the column counter as i.
    // Wide sums make DL underflow land far above SCREEN_W, so one compare clips both.
    always_comb begin
        diag_c    = (mode_q == M_DR) || (mode_q == M_DL);
        xs_c      = (mode_q == M_DL) ? (CW'(ox_q) - CW'(c_q)) : (CW'(ox_q) + CW'(c_q));
        ys_c      = CW'(oy_q) + (diag_c ? CW'(c_q) : CW'(r_q));
        clip_c    = (xs_c >= CW'(SCREEN_W)) || (ys_c >= CW'(SCREEN_H));
        row_end_c = (c_q == w_q - X_W'(1));
        last_c    = row_end_c && (diag_c || (r_q == h_q - Y_W'(1)));
        zero_c    = (w_q == '0) || (!diag_c && (h_q == '0));
        c_nxt     = row_end_c ? '0 : c_q + X_W'(1);
        r_nxt     = row_end_c ? r_q + Y_W'(1) : r_q;
    end

    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= {cmd.cmd_mode, cmd.cmd_x, cmd.cmd_y,
                                    cmd.cmd_w, cmd.cmd_h, cmd.cmd_color};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= S_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            cmd.cmd_ready <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            plot          <= 1'b0;
            x_out         <= '0;
            y_out         <= '0;
            color_out     <= '0;
            mode_q        <= '0;
            ox_q          <= '0;
            oy_q          <= '0;
            w_q           <= '0;
            h_q           <= '0;
            col_q         <= '0;
            c_q           <= '0;
            r_q           <= '0;
            last_q        <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            fifo_cnt      <= cnt_nxt;
            cmd.cmd_ready <= (cnt_nxt != (AW+1)'(FIFO_DEPTH));
            // Busy stays high unless the FSM is about to sit in IDLE with nothing queued.
            busy <= (cnt_nxt != '0) ||
                    !(((state == S_IDLE) && !pop_c) || (state == S_DONE));

            case (state)
                S_IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    if (pop_c) begin
                        mode_q <= hd_mode;
                        col_q  <= hd_color;
                        c_q    <= '0;
                        r_q    <= '0;
                        if (hd_mode == M_CLEAR) begin
                            ox_q <= '0;
                            oy_q <= '0;
                            w_q  <= X_W'(SCREEN_W);
                            h_q  <= Y_W'(SCREEN_H);
                        end else begin
                            ox_q <= hd_x;
                            oy_q <= hd_y;
                            w_q  <= hd_w;
                            h_q  <= hd_h;
                        end
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (zero_c) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        x_out     <= xs_c[X_W-1:0];
                        y_out     <= ys_c[Y_W-1:0];
                        color_out <= col_q;
                        plot      <= !clip_c;
                        last_q    <= last_c;
                        c_q       <= c_nxt;
                        r_q       <= r_nxt;
                        state     <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (last_q) begin
                        plot  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        x_out     <= xs_c[X_W-1:0];
                        y_out     <= ys_c[Y_W-1:0];
                        color_out <= col_q;
                        plot      <= !clip_c;
                        last_q    <= last_c;
                        c_q       <= c_nxt;
                        r_q       <= r_nxt;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
